// File: rtl/if_mem_ctrl.sv
// Instruction-fetch memory controller.
// Turns a 32-bit instruction fetch from the IF stage into four byte reads
// from a byte-wide RAM. The four bytes are assembled little-endian into
// ram_data, and ram_ready pulses for one cycle when the word is complete.
//
// Optional feature: define IF_LAST_HIT_EN to add a one-entry last-fetch
// buffer. A repeat fetch of the last completed address is then answered
// without touching the RAM.
//
// Ports:
//   clk        single clock, rising edge
//   reset_n    synchronous active-low reset
//   ram_read   fetch request, held with ram_addr stable until ram_ready
//   ram_addr   byte address of the requested instruction
//   ram_ready  one-cycle pulse, ram_data valid
//   ram_data   assembled instruction, held until the next completion
//   mem_a      registered byte address to the RAM
//   mem_din    RAM read data, valid one cycle after mem_a
//   mem_wr     RAM write strobe, always 0
module if_mem_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram_read,
    input  logic [31:0] ram_addr,
    output logic        ram_ready,
    output logic [31:0] ram_data,
    output logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    output logic        mem_wr
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      req_addr;
    logic [7:0]       capt0;
    logic [7:0]       capt1;
    logic [7:0]       capt2;

`ifdef IF_LAST_HIT_EN
    logic [31:0]      last_addr;
    logic [31:0]      last_data;
    logic             last_valid;
`endif

    // The controller never writes the instruction RAM.
    assign mem_wr = 1'b0;

    // Fetch sequencer. cnt counts the edges after E0. Addresses +1..+3 go
    // out on cnt 0..2, and bytes come back one cycle behind on cnt 1..4.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            ram_ready <= 1'b0;
            ram_data  <= '0;
            mem_a     <= '0;
            capt0     <= '0;
            capt1     <= '0;
            capt2     <= '0;
`ifdef IF_LAST_HIT_EN
            last_addr  <= '0;
            last_data  <= '0;
            last_valid <= 1'b0;
`endif
        end else begin
            ram_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ram_read) begin
`ifdef IF_LAST_HIT_EN
                        if (last_valid && (ram_addr == last_addr)) begin
                            // Repeat fetch: answer from the buffer and leave mem_a alone.
                            ram_ready <= 1'b1;
                            ram_data  <= last_data;
                            state     <= DONE;
                        end else
`endif
                        begin
                            req_addr <= ram_addr;
                            mem_a    <= ram_addr;
                            cnt      <= '0;
                            state    <= FETCH;
                        end
                    end
                end

                FETCH: begin
                    if (!ram_read) begin
                        // The request was withdrawn, so the captured bytes are dropped.
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (ram_addr != req_addr) begin
                        // The PC moved (flush): restart the fetch at the new address.
                        req_addr <= ram_addr;
                        mem_a    <= ram_addr;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        case (cnt)
                            3'd0: mem_a <= req_addr + 32'd1;
                            3'd1: begin
                                mem_a <= req_addr + 32'd2;
                                capt0 <= mem_din;
                            end
                            3'd2: begin
                                mem_a <= req_addr + 32'd3;
                                capt1 <= mem_din;
                            end
                            3'd3: capt2 <= mem_din;
                            default: begin
                                ram_ready <= 1'b1;
                                ram_data  <= {mem_din, capt2, capt1, capt0};
                                cnt       <= '0;
                                state     <= DONE;
`ifdef IF_LAST_HIT_EN
                                last_addr  <= req_addr;
                                last_data  <= {mem_din, capt2, capt1, capt0};
                                last_valid <= 1'b1;
`endif
                            end
                        endcase
                    end
                end

                // ram_read is ignored here because it still carries the stale PC.
                DONE: state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_mem_ctrl.sv
// Directed testbench for if_mem_ctrl, with a synchronous byte-wide RAM model.
module tb_if_mem_ctrl;

    logic        clk;
    logic        reset_n;
    logic        ram_read;
    logic [31:0] ram_addr;
    logic        ram_ready;
    logic [31:0] ram_data;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic        mem_wr;

    int n_checks;
    int n_errors;
    int pulse_cnt;

    if_mem_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ram_read  (ram_read),
        .ram_addr  (ram_addr),
        .ram_ready (ram_ready),
        .ram_data  (ram_data),
        .mem_a     (mem_a),
        .mem_din   (mem_din),
        .mem_wr    (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: fixed program bytes at 0x100, a hash of the address elsewhere.
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h100: ram_byte = 8'h13;
            32'h101: ram_byte = 8'h05;
            32'h102: ram_byte = 8'h10;
            32'h103: ram_byte = 8'h00;
            default: ram_byte = a[7:0] ^ a[15:8] ^ 8'hC3;
        endcase
    endfunction

    always @(posedge clk) mem_din <= ram_byte(mem_a);

    always @(negedge clk) if (ram_ready === 1'b1) pulse_cnt = pulse_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full-latency fetch starting from IDLE; it ends back in IDLE.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        ram_read = 1'b1;
        ram_addr = addr;
        for (int i = 0; i < 4; i++) begin
            tick;
            check({tag, "_mem_a"}, mem_a, addr + 32'(i));
            check({tag, "_rdy_lo"}, 32'(ram_ready), 32'd0);
        end
        tick;
        check({tag, "_rdy_e4"}, 32'(ram_ready), 32'd0);
        tick;
        check({tag, "_rdy_e5"}, 32'(ram_ready), 32'd1);
        check({tag, "_data"}, ram_data, exp_data);
        ram_read = 1'b0;
        tick;
        check({tag, "_rdy_done"}, 32'(ram_ready), 32'd0);
        check({tag, "_data_hold"}, ram_data, exp_data);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pulse_cnt = 0;
        reset_n   = 1'b0;
        ram_read  = 1'b0;
        ram_addr  = 32'h0;

        // Reset state.
        tick;
        tick;
        check("rst_ready", 32'(ram_ready), 32'd0);
        check("rst_data", ram_data, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        reset_n = 1'b1;
        tick;
        check("idle_mem_a", mem_a, 32'h0);

        // Basic fetch of 0x100.
        fetch("f100", 32'h100, 32'h0010_0513);
        check("pulses_f100", 32'(pulse_cnt), 32'd1);

        // Flush: the address changes after E2, so the fetch restarts at 0x300.
        ram_read = 1'b1;
        ram_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick;
            check("flush_mem_a_old", mem_a, 32'h200 + 32'(i));
        end
        ram_addr = 32'h300;
        tick;
        check("flush_restart", mem_a, 32'h300);
        for (int i = 1; i < 4; i++) begin
            tick;
            check("flush_mem_a_new", mem_a, 32'h300 + 32'(i));
            check("flush_rdy_lo", 32'(ram_ready), 32'd0);
        end
        tick;
        check("flush_rdy_e4", 32'(ram_ready), 32'd0);
        tick;
        check("flush_rdy", 32'(ram_ready), 32'd1);
        check("flush_data", ram_data, 32'hC3C2_C1C0);
        ram_read = 1'b0;
        tick;
        check("pulses_flush", 32'(pulse_cnt), 32'd2);

        // Abort: ram_read drops after E3.
        ram_read = 1'b1;
        ram_addr = 32'h100;
        for (int i = 0; i < 4; i++) tick;
        ram_read = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        check("abort_rdy", 32'(ram_ready), 32'd0);
        check("abort_mem_a", mem_a, 32'h103);
        check("abort_data", ram_data, 32'hC3C2_C1C0);
        check("pulses_abort", 32'(pulse_cnt), 32'd2);
        fetch("after_abort", 32'h100, 32'h0010_0513);
        check("pulses_after_abort", 32'(pulse_cnt), 32'd3);

        // The address wraps past 0xFFFFFFFF.
        fetch("wrap", 32'hFFFF_FFFE, 32'hC2C3_C3C2);
        check("pulses_wrap", 32'(pulse_cnt), 32'd4);

        // Repeat fetch of 0x100.
        fetch("rep1", 32'h100, 32'h0010_0513);
        ram_read = 1'b1;
        ram_addr = 32'h100;
        tick;
`ifdef IF_LAST_HIT_EN
        check("hit_rdy", 32'(ram_ready), 32'd1);
        check("hit_data", ram_data, 32'h0010_0513);
        check("hit_mem_a", mem_a, 32'h103);
        ram_read = 1'b0;
        tick;
        check("hit_rdy_done", 32'(ram_ready), 32'd0);
`else
        check("rep2_rdy_e0", 32'(ram_ready), 32'd0);
        check("rep2_mem_a", mem_a, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("rep2_rdy_lo", 32'(ram_ready), 32'd0);
        end
        tick;
        check("rep2_rdy", 32'(ram_ready), 32'd1);
        check("rep2_data", ram_data, 32'h0010_0513);
        ram_read = 1'b0;
        tick;
`endif
        check("pulses_rep", 32'(pulse_cnt), 32'd6);

        // Reset at E4 of a fetch.
        ram_read = 1'b1;
        ram_addr = 32'h300;
        for (int i = 0; i < 4; i++) tick;
        reset_n = 1'b0;
        tick;
        check("midrst_rdy", 32'(ram_ready), 32'd0);
        check("midrst_data", ram_data, 32'h0);
        check("midrst_mem_a", mem_a, 32'h0);
        reset_n  = 1'b1;
        ram_read = 1'b0;
        for (int i = 0; i < 6; i++) tick;
        check("midrst_late_rdy", 32'(ram_ready), 32'd0);
        check("midrst_mem_a_hold", mem_a, 32'h0);
        check("pulses_midrst", 32'(pulse_cnt), 32'd6);

        // After reset the buffer is empty, so 0x100 goes out to the RAM again.
        fetch("post_rst", 32'h100, 32'h0010_0513);
        check("pulses_final", 32'(pulse_cnt), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_mem_ctrl.md
IF_MEM_CTRL -- requirements
Module: if_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port ram_read, input, 1, fetch request from IF stage, held high with ram_addr stable until ram_ready.
REQ-004 SHALL have port ram_addr, input, 32, byte address of requested instruction.
REQ-005 SHALL have port ram_ready, output, 1, registered one-cycle pulse: ram_data valid.
REQ-006 SHALL have port ram_data, output, 32, assembled instruction, little-endian.
REQ-007 SHALL have port mem_a, output, 32, registered byte address to byte-wide RAM.
REQ-008 SHALL have port mem_din, input, 8, RAM read data, valid one cycle after mem_a presented.
REQ-009 SHALL have port mem_wr, output, 1, RAM write strobe, constant 0.

Function
REQ-010 SHALL implement states IDLE, FETCH, DONE; FETCH holds a 3-bit counter cnt and latched address req_addr.
REQ-011 IDLE, ram_read=1 at edge E0: SHALL latch req_addr=ram_addr, drive mem_a=ram_addr, enter FETCH with cnt=0.
REQ-012 FETCH: SHALL drive mem_a = req_addr+1, +2, +3 at edges E1, E2, E3 (32-bit wrap, carry discarded).
REQ-013 FETCH: SHALL capture mem_din as byte0..byte3 at edges E2..E5.
REQ-014 At E5 SHALL set ram_ready=1, ram_data={byte3,byte2,byte1,byte0}, enter DONE; ram_ready high only in cycle following E5.
REQ-015 DONE: SHALL clear ram_ready at next edge, ignore ram_read that cycle (stale pc), return to IDLE; ram_data holds value until next completion.
REQ-016 FETCH, ram_read=0 sampled: SHALL abort, discard captured bytes, return to IDLE, no ram_ready.
REQ-017 FETCH, ram_read=1 and ram_addr!=req_addr (flush): SHALL restart as REQ-011 with new address, no ram_ready for old address.
REQ-018 IDLE, ram_read=0: SHALL hold mem_a, ram_ready=0.
REQ-019 Back-to-back requests SHALL yield one ram_ready per 7 cycles minimum without REQ-025 hit.

Reset
REQ-020 reset_n=0 at edge SHALL force state IDLE, cnt=0, req_addr=0.
REQ-021 Reset SHALL force ram_ready=0, ram_data=0, mem_a=0, mem_wr=0.
REQ-022 Reset mid-FETCH or in DONE SHALL abort with no ram_ready pulse after reset edge.
REQ-023 Reset SHALL take priority over all other conditions at the same edge.

Configuration
REQ-024 Macro IF_LAST_HIT_EN SHALL enable a one-entry last-fetch buffer (last_addr, last_data, last_valid).
REQ-025 With IF_LAST_HIT_EN: every completion SHALL load buffer and set last_valid; IDLE with ram_read=1, last_valid=1, ram_addr==last_addr SHALL set ram_ready=1, ram_data=last_data at E0 and enter DONE, no RAM access.
REQ-026 With IF_LAST_HIT_EN: last_valid SHALL clear only on reset; aborted fetches SHALL not update buffer.
REQ-027 Without IF_LAST_HIT_EN: buffer SHALL be absent; every request SHALL take full FETCH path.

Verification
REQ-028 RAM[0x100..0x103]=13,05,10,00; ram_read=1, ram_addr=0x100 -> mem_a 0x100..0x103 on E0..E3, ram_ready single pulse after E5, ram_data=0x00100513.
REQ-029 Request 0x200 then ram_addr->0x300 after E2 -> fetch restarts at 0x300, single ram_ready with RAM[0x300..0x303] data, none for 0x200.
REQ-030 ram_read dropped after E3 -> no ram_ready, state IDLE, next request 0x100 completes normally.
REQ-031 reset_n=0 at E4 of fetch -> ram_ready=0, ram_data=0, mem_a=0 afterwards, no late pulse.
REQ-032 ram_addr=0xFFFFFFFE -> mem_a 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-033 IF_LAST_HIT_EN defined: fetch 0x100 twice -> second ram_ready in cycle after E0 with 0x00100513, mem_a unchanged; macro undefined -> second fetch takes full latency.
